// File: rtl/gnt_ack_arbiter.sv
// Round-robin arbiter for one shared resource: registered one-hot grant held until ack
// arrives in the 1..MAX_WAIT window after grant rise, or until timeout.
module gnt_ack_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 ack,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 stray_ack,
    output logic [CNT_W-1:0]     timeout_cnt
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IW-1:0]    gnt_id_q, gnt_id_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             stray_q, stray_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [IW-1:0]    last_q, last_d;

    logic             found;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    cand;

    // Scan from last+1 upward with wrap; the first asserted request wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IW'((32'(last_q) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        stray_d    = 1'b0;
        tcnt_d     = tcnt_q;
        wait_cnt_d = wait_cnt_q;
        last_d     = last_q;
        unique case (state_q)
            StIdle: begin
                stray_d = ack;
                if (found) begin
                    state_d    = StWait;
                    gnt_d      = {{(N-1){1'b0}}, 1'b1} << pick;
                    gnt_id_d   = pick;
                    busy_d     = 1'b1;
                    wait_cnt_d = '0;
                end
            end
            StWait: begin
                if (wait_cnt_q == '0) begin
                    // Ack in the grant-rise cycle is too early to be a real completion.
                    stray_d    = ack;
                    wait_cnt_d = WW'(1);
                end else if (ack || (wait_cnt_q == WAIT_LAST)) begin
                    done_d    = ack;
                    timeout_d = !ack;
                    if (!ack && (tcnt_q != '1)) begin
                        tcnt_d = tcnt_q + CNT_W'(1);
                    end
                    state_d = StIdle;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    last_d  = gnt_id_q;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            stray_q    <= 1'b0;
            tcnt_q     <= '0;
            wait_cnt_q <= '0;
            last_q     <= IW'(N - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            stray_q    <= stray_d;
            tcnt_q     <= tcnt_d;
            wait_cnt_q <= wait_cnt_d;
            last_q     <= last_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign stray_ack   = stray_q;
    assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_gnt_ack_arbiter.sv
// Bench for gnt_ack_arbiter: expected grant/done/timeout/stray events are queued with their
// cycle numbers as stimulus is driven, and matched when the DUT shows them.
module tb_gnt_ack_arbiter;

    localparam int N        = 4;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 8;

    localparam int EV_GRANT = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_TO    = 2;
    localparam int EV_STRAY = 3;

    typedef struct {
        int kind;
        int val;
        int at;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             ack;
    logic [N-1:0]     gnt;
    logic [1:0]       gnt_id;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             stray_ack;
    logic [CNT_W-1:0] timeout_cnt;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ref_to = 0;
    ev_t  sb[$];
    logic [N-1:0] prev_gnt = '0;

    gnt_ack_arbiter #(.N(N), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .ack         (ack),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .stray_ack   (stray_ack),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic match(input int kind, input int val);
        ev_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", kind, 32'hffff_ffff);
            return;
        end
        e = sb.pop_front();
        check("ev_kind", kind, e.kind);
        check("ev_val", val, e.val);
        check("ev_cycle", cyc, e.at);
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        idx_of = 0;
        for (int i = 0; i < N; i++) if (v[i]) idx_of = i;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an idle cycle: drives r, expects grant eg next cycle. ak = 1..MAX_WAIT acks at
    // G+ak, ak = 0 acks only at G (stray then timeout), anything else never acks.
    task automatic serve(input logic [N-1:0] r, input logic [N-1:0] eg, input int ak);
        int  g;
        int  lk;
        bit  is_to;
        is_to = !(ak >= 1 && ak <= MAX_WAIT);
        lk    = is_to ? MAX_WAIT : ak;
        g     = cyc + 1;
        req   = r;
        ack   = 1'b0;
        push(EV_GRANT, int'(eg), g);
        if (ak == 0) push(EV_STRAY, 0, g + 1);
        push(is_to ? EV_TO : EV_DONE, 0, g + lk + 1);
        tick();
        for (int k = 0; k <= lk; k++) begin
            check("gnt_held", gnt, eg);
            check("busy_held", busy, 1);
            check("gnt_id", gnt_id, idx_of(eg));
            ack = (k == ak);
            tick();
        end
        ack = 1'b0;
        check("gnt_released", gnt, 0);
        check("busy_released", busy, 0);
        if (is_to) ref_to++;
        check("timeout_cnt", timeout_cnt, sat(ref_to));
        req = '0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (rst_n) begin
                check("gnt_onehot0", $onehot0(gnt), 1);
                check("busy_vs_gnt", busy, |gnt);
                check("pulse_excl", (int'(done) + int'(timeout) + int'(stray_ack)) <= 1, 1);
                if (|gnt && !(|prev_gnt)) match(EV_GRANT, int'(gnt));
                if (stray_ack) match(EV_STRAY, 0);
                if (done) match(EV_DONE, 0);
                if (timeout) match(EV_TO, 0);
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        req   = '0;
        ack   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_stray", stray_ack, 0);
        check("rst_tcnt", timeout_cnt, 0);
        #3 rst_n = 1'b1;
        tick();

        // Single request, ack two cycles after grant rise.
        serve(4'b0001, 4'b0001, 2);

        // All requesting: rotation continues from requester 0, period k+2 = 4.
        serve(4'b1111, 4'b0010, 2);
        serve(4'b1111, 4'b0100, 2);
        serve(4'b1111, 4'b1000, 2);
        serve(4'b1111, 4'b0001, 2);
        serve(4'b1111, 4'b0010, 2);

        // No ack: grant held G..G+4, timeout at G+5; then rotation resumes after 2.
        serve(4'b0100, 4'b0100, -1);
        serve(4'b1111, 4'b1000, 2);

        // Window edges.
        serve(4'b1111, 4'b0001, 1);
        serve(4'b1111, 4'b0010, MAX_WAIT);
        serve(4'b1111, 4'b0100, 0);

        // Ack while idle is stray.
        tick();
        ack = 1'b1;
        push(EV_STRAY, 0, cyc + 1);
        tick();
        ack = 1'b0;
        tick();

        // Saturate the timeout counter.
        for (int i = 0; i < 256; i++) serve(4'b0001, 4'b0001, -1);
        check("tcnt_saturated", timeout_cnt, 255);

        // Asynchronous reset in the middle of a grant.
        req = 4'b0100;
        g   = cyc + 1;
        push(EV_GRANT, 4, g);
        tick();
        tick();
        tick();
        check("pre_rst_gnt", gnt, 4'b0100);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", gnt, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_tcnt", timeout_cnt, 0);
        check("async_rst_gnt_id", gnt_id, 0);
        ref_to = 0;
        req    = '0;
        #2 rst_n = 1'b1;
        tick();
        serve(4'b1111, 4'b0001, 2);
        repeat (3) tick();

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gnt_ack_arbiter.md
Name: gnt_ack_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource between N requesters.
- Issues a registered one-hot grant and holds it until the resource returns ack within a 1..MAX_WAIT cycle window after the grant rises. This is the behaviour checked by the team's gnt ##[1:4] ack property.
- Releases the grant on ack or on timeout, flags stray acks, and keeps a saturating timeout count for the testbench and assertions.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_WAIT, 4, last cycle after grant rise in which ack is accepted (>=1).
- CNT_W, 8, width of the saturating timeout counter.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request level.
- ack  input  1  completion from the shared resource.
- gnt  output  N  one-hot grant, held while waiting.
- gnt_id  output  $clog2(N)  index of the granted requester; valid while busy=1.
- busy  output  1  high while gnt is asserted (state WAIT).
- done  output  1  one-cycle pulse: an ack was accepted.
- timeout  output  1  one-cycle pulse: no ack arrived within the window.
- stray_ack  output  1  one-cycle pulse: ack arrived outside the window.
- timeout_cnt  output  CNT_W  saturating count of timeouts.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: gnt=0, gnt_id=0, busy=0, done=0, timeout=0, stray_ack=0, timeout_cnt=0.
  - state=IDLE, last=N-1, so requester 0 has highest priority first.
  - Reset mid-WAIT drops gnt immediately; no done or timeout is generated.
- States: IDLE, WAIT. wait_cnt counts cycles since grant rise: 0 in the first gnt-high cycle G, saturating at MAX_WAIT.
- IDLE:
  - If |req in cycle t, select the first asserted req scanning from (last+1) mod N upward with wrap.
  - gnt goes high at cycle t+1 (=G); gnt_id and busy go high together with gnt. state->WAIT, wait_cnt=0.
  - If req=0, stay in IDLE.
  - An ack in IDLE is ignored; stray_ack=1 the next cycle.
- WAIT:
  - gnt is held constant regardless of req changes; deasserting req does not withdraw the grant.
  - ack sampled in cycle G (wait_cnt=0): ignored; stray_ack=1 at G+1; keep waiting.
  - ack sampled in cycle G+k, 1<=k<=MAX_WAIT: at G+k+1 gnt=0, busy=0, done=1; last=gnt_id; state->IDLE.
  - No ack through cycle G+MAX_WAIT: at G+MAX_WAIT+1 gnt=0, busy=0, timeout=1; timeout_cnt+1, saturating at 2^CNT_W-1; last=gnt_id; state->IDLE.
- Grant spacing: gnt is low for at least one cycle between grants, so every grant produces a distinct rising edge. Back-to-back service gives a gnt period of k+2 cycles.
- Output encoding: done, timeout and stray_ack are registered single-cycle pulses and are mutually exclusive with each other in a given cycle. gnt is always zero or one-hot.
- Fairness: with all req held high, consecutive grants go to 0,1,...,N-1,0. Any requester waits at most N-1 other grants.

Test Plan (N=4, MAX_WAIT=4):
1. req=0001 at cycle 0, ack pulsed at cycle 3 -> gnt=0001 cycles 1..3; done=1 and gnt=0 at cycle 4; timeout_cnt=0.
2. req=1111 held, ack pulsed 2 cycles after each grant rise -> grant order 0001,0010,0100,1000,0001; gnt period 4 cycles; no timeout, no stray_ack.
3. req=0100, ack never asserted -> gnt=0100 for exactly 5 cycles (G..G+4); timeout=1 at G+5; timeout_cnt=1. Then with req=1111 -> next grant is 1000.
4. Window edges: ack at G+1 -> done at G+2; ack at G+4 -> done at G+5 with timeout=0; ack only at G -> stray_ack at G+1, then timeout at G+5.
5. Force timeout_cnt to 255 with 256 timeouts -> timeout_cnt stays 255 after the 256th timeout.
6. rst_n pulled low at G+2 of a pending grant -> gnt, busy and timeout_cnt go to 0 without a clock edge. After release with req=1111 -> first grant is 0001.
